// File: rtl/ahb_wbuf_bridge.sv
// ahb_wbuf_bridge
// AHB-lite posted-write bridge. Upstream writes are absorbed into a small FIFO
// with zero wait states and drained to the downstream slave in the background.
// Upstream reads wait for the FIFO to drain, then run as a single downstream
// transfer. Downstream only ever sees IDLE or NONSEQ single transfers.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   ahbls_*               upstream AHB-lite slave port (hresp tied 0)
//   ahbm_*                downstream AHB-lite master port (hburst tied SINGLE)
//   wbuf_count/wbuf_empty write FIFO occupancy
//   werr / werr_clr       sticky posted-write error flag and its clear
//
// WBUF_DEPTH must be a power of two and at least 2.
//
// Master FSM
//   state  | meaning
//   M_IDLE | no downstream transfer; picks FIFO head first, then a pending read
//   M_ADDR | downstream address phase (NONSEQ) held until ahbm_hready
//   M_DATA | downstream data phase; pops the FIFO or captures read data
module ahb_wbuf_bridge #(
    parameter int W_ADDR     = 32,
    parameter int W_DATA     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ahbls_hready,
    output logic                        ahbls_hready_resp,
    output logic                        ahbls_hresp,
    input  logic [W_ADDR-1:0]           ahbls_haddr,
    input  logic                        ahbls_hwrite,
    input  logic [1:0]                  ahbls_htrans,
    input  logic [2:0]                  ahbls_hsize,
    input  logic [W_DATA-1:0]           ahbls_hwdata,
    output logic [W_DATA-1:0]           ahbls_hrdata,
    output logic [W_ADDR-1:0]           ahbm_haddr,
    output logic                        ahbm_hwrite,
    output logic [1:0]                  ahbm_htrans,
    output logic [2:0]                  ahbm_hsize,
    output logic [2:0]                  ahbm_hburst,
    output logic [W_DATA-1:0]           ahbm_hwdata,
    input  logic [W_DATA-1:0]           ahbm_hrdata,
    input  logic                        ahbm_hready,
    input  logic                        ahbm_hresp,
    output logic [$clog2(WBUF_DEPTH):0] wbuf_count,
    output logic                        wbuf_empty,
    output logic                        werr,
    input  logic                        werr_clr
);

    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {M_IDLE, M_ADDR, M_DATA} m_state_t;

    m_state_t          m_state;
    logic              dp_valid;
    logic              dp_write;
    logic [W_ADDR-1:0] dp_addr;
    logic [2:0]        dp_size;
    logic              rd_done;

    logic [W_ADDR-1:0] fifo_addr [WBUF_DEPTH];
    logic [2:0]        fifo_size [WBUF_DEPTH];
    logic [W_DATA-1:0] fifo_data [WBUF_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic up_aphase;
    logic wbuf_full;
    logic push;
    logic pop;
    logic unused_htrans0;

    // SEQ behaves as NONSEQ and BUSY as IDLE, so only htrans[1] matters.
    assign up_aphase      = ahbls_htrans[1] && ahbls_hready;
    assign unused_htrans0 = ahbls_htrans[0];

    assign wbuf_full  = (count == CW'(WBUF_DEPTH));
    assign wbuf_empty = (count == '0);
    assign wbuf_count = count;

    // Built from registered state only; nothing from ahbm_* reaches this path.
    assign ahbls_hready_resp = !dp_valid ? 1'b1 : (dp_write ? !wbuf_full : rd_done);
    assign ahbls_hresp       = 1'b0;
    assign ahbm_hburst       = 3'b000;

    assign push = dp_valid && dp_write && !wbuf_full;
    assign pop  = (m_state == M_DATA) && ahbm_hready && ahbm_hwrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
            dp_size  <= '0;
        end else if (ahbls_hready) begin
            dp_valid <= up_aphase;
            dp_write <= ahbls_hwrite;
            dp_addr  <= ahbls_haddr;
            dp_size  <= ahbls_hsize;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= dp_addr;
            fifo_size[wr_ptr] <= dp_size;
            fifo_data[wr_ptr] <= ahbls_hwdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            werr <= 1'b0;
        end else begin
            if (werr_clr)            werr <= 1'b0;
            if (pop && ahbm_hresp)   werr <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state      <= M_IDLE;
            ahbm_htrans  <= HTRANS_IDLE;
            ahbm_haddr   <= '0;
            ahbm_hwrite  <= 1'b0;
            ahbm_hsize   <= '0;
            ahbm_hwdata  <= '0;
            ahbls_hrdata <= '0;
            rd_done      <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            case (m_state)
                M_IDLE: begin
                    if (count != '0) begin
                        m_state     <= M_ADDR;
                        ahbm_htrans <= HTRANS_NONSEQ;
                        ahbm_haddr  <= fifo_addr[rd_ptr];
                        ahbm_hsize  <= fifo_size[rd_ptr];
                        ahbm_hwrite <= 1'b1;
                    end else if (push) begin
                        // FIFO empty: the entry being pushed now becomes the head,
                        // so issue it straight from the data-phase register.
                        m_state     <= M_ADDR;
                        ahbm_htrans <= HTRANS_NONSEQ;
                        ahbm_haddr  <= dp_addr;
                        ahbm_hsize  <= dp_size;
                        ahbm_hwrite <= 1'b1;
                    end else if (dp_valid && !dp_write && !rd_done) begin
                        // Read that waited behind queued writes.
                        m_state     <= M_ADDR;
                        ahbm_htrans <= HTRANS_NONSEQ;
                        ahbm_haddr  <= dp_addr;
                        ahbm_hsize  <= dp_size;
                        ahbm_hwrite <= 1'b0;
                    end else if (up_aphase && !ahbls_hwrite) begin
                        // Read address phase with nothing queued: start downstream
                        // in the very next cycle.
                        m_state     <= M_ADDR;
                        ahbm_htrans <= HTRANS_NONSEQ;
                        ahbm_haddr  <= ahbls_haddr;
                        ahbm_hsize  <= ahbls_hsize;
                        ahbm_hwrite <= 1'b0;
                    end
                end
                M_ADDR: begin
                    if (ahbm_hready) begin
                        m_state     <= M_DATA;
                        ahbm_htrans <= HTRANS_IDLE;
                        if (ahbm_hwrite) ahbm_hwdata <= fifo_data[rd_ptr];
                    end
                end
                M_DATA: begin
                    if (ahbm_hready) begin
                        m_state <= M_IDLE;
                        if (!ahbm_hwrite) begin
                            ahbls_hrdata <= ahbm_hrdata;
                            rd_done      <= 1'b1;
                        end
                    end
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_wbuf_bridge.sv
// Self-checking bench for ahb_wbuf_bridge: a table of per-cycle vectors for a
// single posted write and a stretched read, then directed sequences for FIFO
// full stall, write-then-read ordering, error flag handling and mid-drain reset.
module tb_ahb_wbuf_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ahbls_hready;
    logic        ahbls_hready_resp;
    logic        ahbls_hresp;
    logic [31:0] up_haddr = '0;
    logic        up_hwrite = 1'b0;
    logic [1:0]  up_htrans = '0;
    logic [2:0]  up_hsize = 3'b010;
    logic [31:0] up_hwdata = '0;
    logic [31:0] ahbls_hrdata;
    logic [31:0] ahbm_haddr;
    logic        ahbm_hwrite;
    logic [1:0]  ahbm_htrans;
    logic [2:0]  ahbm_hsize;
    logic [2:0]  ahbm_hburst;
    logic [31:0] ahbm_hwdata;
    logic [31:0] s_rdata = '0;
    logic        s_rdy = 1'b1;
    logic        s_err = 1'b0;
    logic [2:0]  wbuf_count;
    logic        wbuf_empty;
    logic        werr;
    logic        werr_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Single-slave system: the bus hready is this slave's own response.
    assign ahbls_hready = ahbls_hready_resp;

    ahb_wbuf_bridge #(.W_ADDR(32), .W_DATA(32), .WBUF_DEPTH(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ahbls_hready      (ahbls_hready),
        .ahbls_hready_resp (ahbls_hready_resp),
        .ahbls_hresp       (ahbls_hresp),
        .ahbls_haddr       (up_haddr),
        .ahbls_hwrite      (up_hwrite),
        .ahbls_htrans      (up_htrans),
        .ahbls_hsize       (up_hsize),
        .ahbls_hwdata      (up_hwdata),
        .ahbls_hrdata      (ahbls_hrdata),
        .ahbm_haddr        (ahbm_haddr),
        .ahbm_hwrite       (ahbm_hwrite),
        .ahbm_htrans       (ahbm_htrans),
        .ahbm_hsize        (ahbm_hsize),
        .ahbm_hburst       (ahbm_hburst),
        .ahbm_hwdata       (ahbm_hwdata),
        .ahbm_hrdata       (s_rdata),
        .ahbm_hready       (s_rdy),
        .ahbm_hresp        (s_err),
        .wbuf_count        (wbuf_count),
        .wbuf_empty        (wbuf_empty),
        .werr              (werr),
        .werr_clr          (werr_clr)
    );

    // Downstream transfer log, filled as each data phase completes.
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       xq[$];
    xfer_t       cur;
    logic        dph_pend = 1'b0;
    int          max_seen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            dph_pend = 1'b0;
        end else begin
            if (dph_pend && s_rdy) begin
                cur.data = cur.wr ? ahbm_hwdata : s_rdata;
                xq.push_back(cur);
                dph_pend = 1'b0;
            end
            if (ahbm_htrans == 2'b10 && s_rdy) begin
                dph_pend = 1'b1;
                cur.addr = ahbm_haddr;
                cur.wr   = ahbm_hwrite;
                cur.data = '0;
            end
            if (int'(wbuf_count) > max_seen) max_seen = int'(wbuf_count);
        end
    end

    typedef struct {
        logic [1:0]  htrans;
        logic        hwrite;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic        s_rdy;
        logic [31:0] s_rdata;
        logic        e_resp;
        logic [1:0]  e_mtrans;
        logic [31:0] e_maddr;
        logic        ca;
        logic [31:0] e_mwdata;
        logic        cw;
        logic [31:0] e_rdata;
        logic        cr;
        logic [2:0]  e_count;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic [1:0] htrans, input logic hwrite,
                                input logic [31:0] haddr, input logic [31:0] hwdata,
                                input logic rdy, input logic [31:0] rdata,
                                input logic e_resp, input logic [1:0] e_mtrans,
                                input logic [31:0] e_maddr, input logic ca,
                                input logic [31:0] e_mwdata, input logic cw,
                                input logic [31:0] e_rdata, input logic cr,
                                input logic [2:0] e_count);
        vec_t v;
        v.htrans = htrans;  v.hwrite = hwrite;   v.haddr = haddr;  v.hwdata = hwdata;
        v.s_rdy = rdy;      v.s_rdata = rdata;   v.e_resp = e_resp;
        v.e_mtrans = e_mtrans; v.e_maddr = e_maddr; v.ca = ca;
        v.e_mwdata = e_mwdata; v.cw = cw; v.e_rdata = e_rdata; v.cr = cr;
        v.e_count = e_count;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Holds the currently driven upstream signals until the slave is ready.
    task automatic wait_resp(input string name, output int waits, output logic [31:0] rd);
        waits = 0;
        rd = '0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (ahbls_hready_resp) begin
                rd = ahbls_hrdata;
                @(posedge clk);
                #1;
                return;
            end
            waits++;
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL %s: hready_resp timeout, got 0 expected 1", name);
    endtask

    task automatic ahb_step(input string name, input logic [1:0] tr, input logic wr,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int waits, output logic [31:0] rd);
        up_htrans = tr;
        up_hwrite = wr;
        up_haddr  = a;
        up_hwdata = wd;
        wait_resp(name, waits, rd);
    endtask

    task automatic wait_empty(input string name);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (wbuf_empty && ahbm_htrans == 2'b00 && !dph_pend) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL %s: drain timeout, wbuf_count=%0d expected 0", name, wbuf_count);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          base;
        logic [31:0] rd;
        logic        found;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hready_resp", 32'(ahbls_hready_resp), 32'd1);
        chk("rst_hresp",       32'(ahbls_hresp),       32'd0);
        chk("rst_hrdata",      ahbls_hrdata,           32'd0);
        chk("rst_m_htrans",    32'(ahbm_htrans),       32'd0);
        chk("rst_m_haddr",     ahbm_haddr,             32'd0);
        chk("rst_m_hwrite",    32'(ahbm_hwrite),       32'd0);
        chk("rst_m_hsize",     32'(ahbm_hsize),        32'd0);
        chk("rst_m_hburst",    32'(ahbm_hburst),       32'd0);
        chk("rst_m_hwdata",    ahbm_hwdata,            32'd0);
        chk("rst_wbuf_count",  32'(wbuf_count),        32'd0);
        chk("rst_wbuf_empty",  32'(wbuf_empty),        32'd1);
        chk("rst_werr",        32'(werr),              32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle_htrans_%0d", i), 32'(ahbm_htrans), 32'd0);
            @(posedge clk);
            #1;
        end

        // Table: single posted write (downstream always ready), then a read of
        // 0x300 whose downstream data phase lasts 3 cycles (address phase in
        // vector 5 = cycle 0, data completes in vector 9 = cycle k = 4).
        vecs[0]  = mk(2'b10, 1'b1, 32'h100, 32'h0,        1'b1, 32'h0,        1'b1, 2'b00, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 3'd0);
        vecs[1]  = mk(2'b00, 1'b0, 32'h0,   32'hDEADBEEF, 1'b1, 32'h0,        1'b1, 2'b00, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 3'd0);
        vecs[2]  = mk(2'b00, 1'b0, 32'h0,   32'h0,        1'b1, 32'h0,        1'b1, 2'b10, 32'h100, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 3'd1);
        vecs[3]  = mk(2'b00, 1'b0, 32'h0,   32'h0,        1'b1, 32'h0,        1'b1, 2'b00, 32'h0,   1'b0, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 3'd1);
        vecs[4]  = mk(2'b00, 1'b0, 32'h0,   32'h0,        1'b1, 32'h0,        1'b1, 2'b00, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 3'd0);
        vecs[5]  = mk(2'b10, 1'b0, 32'h300, 32'h0,        1'b1, 32'h0,        1'b1, 2'b00, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 3'd0);
        vecs[6]  = mk(2'b00, 1'b0, 32'h0,   32'h0,        1'b1, 32'h0,        1'b0, 2'b10, 32'h300, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 3'd0);
        vecs[7]  = mk(2'b00, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 2'b00, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 3'd0);
        vecs[8]  = mk(2'b00, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0,        1'b0, 2'b00, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 3'd0);
        vecs[9]  = mk(2'b00, 1'b0, 32'h0,   32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 2'b00, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 3'd0);
        vecs[10] = mk(2'b00, 1'b0, 32'h0,   32'h0,        1'b1, 32'h0,        1'b1, 2'b00, 32'h0,   1'b0, 32'h0,        1'b0, 32'hCAFEF00D, 1'b1, 3'd0);
        vecs[11] = mk(2'b00, 1'b0, 32'h0,   32'h0,        1'b1, 32'h0,        1'b1, 2'b00, 32'h0,   1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 3'd0);

        for (int i = 0; i < 12; i++) begin
            up_htrans = vecs[i].htrans;
            up_hwrite = vecs[i].hwrite;
            up_haddr  = vecs[i].haddr;
            up_hwdata = vecs[i].hwdata;
            s_rdy     = vecs[i].s_rdy;
            s_rdata   = vecs[i].s_rdata;
            @(negedge clk);
            chk($sformatf("vec%0d_hready_resp", i), 32'(ahbls_hready_resp), 32'(vecs[i].e_resp));
            chk($sformatf("vec%0d_m_htrans", i), 32'(ahbm_htrans), 32'(vecs[i].e_mtrans));
            chk($sformatf("vec%0d_wbuf_count", i), 32'(wbuf_count), 32'(vecs[i].e_count));
            if (vecs[i].ca) chk($sformatf("vec%0d_m_haddr", i), ahbm_haddr, vecs[i].e_maddr);
            if (vecs[i].cw) chk($sformatf("vec%0d_m_hwdata", i), ahbm_hwdata, vecs[i].e_mwdata);
            if (vecs[i].cr) chk($sformatf("vec%0d_hrdata", i), ahbls_hrdata, vecs[i].e_rdata);
            @(posedge clk);
            #1;
        end

        // Six back-to-back writes with the downstream stalled.
        base  = xq.size();
        s_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ahb_step($sformatf("stall_wr%0d", i), 2'b10, 1'b1, 32'(i * 4),
                     (i == 0) ? 32'h0 : 32'hA000_0000 + 32'(i - 1), w, rd);
            chk($sformatf("stall_wr%0d_waits", i), 32'(w), 32'd0);
        end
        up_htrans = 2'b10;
        up_hwrite = 1'b1;
        up_haddr  = 32'h14;
        up_hwdata = 32'hA000_0004;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("full_resp_%0d", i), 32'(ahbls_hready_resp), 32'd0);
            chk($sformatf("full_count_%0d", i), 32'(wbuf_count), 32'd4);
            @(posedge clk);
            #1;
        end
        s_rdy = 1'b1;
        wait_resp("stall_release", w, rd);
        ahb_step("stall_last_data", 2'b00, 1'b0, 32'h0, 32'hA000_0005, w, rd);
        up_hwdata = '0;
        wait_empty("stall_drain");
        chk("stall_xfer_count", 32'(xq.size() - base), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (base + i < xq.size()) begin
                chk($sformatf("stall_order_addr%0d", i), xq[base + i].addr, 32'(i * 4));
                chk($sformatf("stall_order_data%0d", i), xq[base + i].data, 32'hA000_0000 + 32'(i));
                chk($sformatf("stall_order_wr%0d", i), 32'(xq[base + i].wr), 32'd1);
            end
        end
        chk("peak_wbuf_count", 32'(max_seen), 32'd4);

        // Write then immediate read of the same address.
        base    = xq.size();
        s_rdata = 32'h11223344;
        ahb_step("wr_rd_aph_w", 2'b10, 1'b1, 32'h200, 32'h0, w, rd);
        ahb_step("wr_rd_aph_r", 2'b10, 1'b0, 32'h200, 32'h11223344, w, rd);
        ahb_step("wr_rd_dph_r", 2'b00, 1'b0, 32'h0, 32'h0, w, rd);
        chk("wr_rd_hrdata", rd, 32'h11223344);
        wait_empty("wr_rd_drain");
        chk("wr_rd_xfer_count", 32'(xq.size() - base), 32'd2);
        if (xq.size() >= base + 2) begin
            chk("wr_rd_first_is_write", 32'(xq[base].wr), 32'd1);
            chk("wr_rd_first_addr", xq[base].addr, 32'h200);
            chk("wr_rd_first_data", xq[base].data, 32'h11223344);
            chk("wr_rd_second_is_read", 32'(xq[base + 1].wr), 32'd0);
            chk("wr_rd_second_addr", xq[base + 1].addr, 32'h200);
        end
        s_rdata = '0;

        // Posted write error: sticky flag, clear, coincident clear and error.
        s_err = 1'b1;
        ahb_step("err_aph", 2'b10, 1'b1, 32'h400, 32'h0, w, rd);
        ahb_step("err_dph", 2'b00, 1'b0, 32'h0, 32'h55, w, rd);
        wait_empty("err_drain");
        s_err = 1'b0;
        @(negedge clk);
        chk("werr_set", 32'(werr), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("werr_sticky", 32'(werr), 32'd1);
        @(posedge clk);
        #1 werr_clr = 1'b1;
        @(posedge clk);
        #1 werr_clr = 1'b0;
        @(negedge clk);
        chk("werr_cleared", 32'(werr), 32'd0);
        @(posedge clk);
        #1;

        s_err = 1'b1;
        ahb_step("errclr_aph", 2'b10, 1'b1, 32'h404, 32'h0, w, rd);
        ahb_step("errclr_dph", 2'b00, 1'b0, 32'h0, 32'h66, w, rd);
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            if (ahbm_htrans == 2'b10) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("errclr_nonseq_seen", 32'(found), 32'd1);
        @(posedge clk);
        #1 werr_clr = 1'b1;
        @(posedge clk);
        #1 werr_clr = 1'b0;
        s_err = 1'b0;
        @(negedge clk);
        chk("werr_clr_vs_error", 32'(werr), 32'd1);
        @(posedge clk);
        #1;
        wait_empty("errclr_drain");

        // Reset in the middle of a stalled drain.
        s_rdy = 1'b0;
        ahb_step("rst_wr0", 2'b10, 1'b1, 32'h500, 32'h0, w, rd);
        ahb_step("rst_wr1", 2'b10, 1'b1, 32'h504, 32'hB000_0000, w, rd);
        ahb_step("rst_wr2", 2'b10, 1'b1, 32'h508, 32'hB000_0001, w, rd);
        ahb_step("rst_wr3", 2'b00, 1'b0, 32'h0,   32'hB000_0002, w, rd);
        @(negedge clk);
        chk("pre_rst_count", 32'(wbuf_count), 32'd3);
        chk("pre_rst_htrans", 32'(ahbm_htrans), 32'd2);
        #2 rst_n = 1'b0;
        up_htrans = 2'b00;
        #1;
        chk("mid_rst_count", 32'(wbuf_count), 32'd0);
        chk("mid_rst_empty", 32'(wbuf_empty), 32'd1);
        chk("mid_rst_htrans", 32'(ahbm_htrans), 32'd0);
        chk("mid_rst_resp", 32'(ahbls_hready_resp), 32'd1);
        chk("mid_rst_werr", 32'(werr), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        s_rdy = 1'b1;
        base  = xq.size();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_htrans_%0d", i), 32'(ahbm_htrans), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("post_rst_no_xfers", 32'(xq.size() - base), 32'd0);
        chk("post_rst_count", 32'(wbuf_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
